// File: rtl/pi_l1_pkg.sv
// Shared constants and FSM encoding for the multiplexed PI regulator.
package pi_l1_pkg;
   localparam int DEF_DATA_WIDTH         = 32;
   localparam int DEF_DATA_WIDTH_DECIMAL = 24;
   localparam int DEF_N_CH               = 4;

   localparam logic [DEF_DATA_WIDTH-1:0] ONE = DEF_DATA_WIDTH'(1) << DEF_DATA_WIDTH_DECIMAL;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_P = 2'd1,
      MUL_I = 2'd2,
      SAT   = 2'd3
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker; the search starts one past the last granted channel.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            aclk,
   input  logic            resetn,
   input  logic            en,
   input  logic [N_CH-1:0] req,
   output logic [N_CH-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            found
);
   logic [IW-1:0] ptr_q, ptr_d, cand;

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand = IW'((int'(ptr_q) + k) % N_CH);
         if (!found && req[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      if (en && found) begin
         grant[grant_idx] = 1'b1;
         ptr_d = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!resetn) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
endmodule

// File: rtl/pi_mux_l1.sv
// N_CH PI regulators time-sharing one multiplier; one channel updated per 4 enabled cycles.
module pi_mux_l1
   import pi_l1_pkg::*;
#(
   parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
   parameter int DATA_WIDTH_DECIMAL = DEF_DATA_WIDTH_DECIMAL,
   parameter int N_CH               = DEF_N_CH
) (
   input  logic                       aclk,
   input  logic                       resetn,
   input  logic                       ce,
   input  logic [N_CH-1:0]            req_valid,
   output logic [N_CH-1:0]            req_ready,
   input  logic [N_CH*DATA_WIDTH-1:0] in,
   input  logic [N_CH*DATA_WIDTH-1:0] reference,
   input  logic [N_CH*DATA_WIDTH-1:0] kp,
   input  logic [N_CH*DATA_WIDTH-1:0] ki,
   input  logic [DATA_WIDTH-1:0]      max,
   input  logic [DATA_WIDTH-1:0]      min,
   input  logic [N_CH-1:0]            int_clr,
   output logic [N_CH*DATA_WIDTH-1:0] out,
   output logic [N_CH-1:0]            out_valid
);
   localparam int DW = DATA_WIDTH;
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

   function automatic logic signed [DW-1:0] clamp(input logic signed [DW:0]   v,
                                                  input logic signed [DW-1:0] hi,
                                                  input logic signed [DW-1:0] lo);
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v[DW-1:0];
   endfunction

   // One guard bit so the sum can never wrap before it is clamped.
   function automatic logic signed [DW:0] add_wide(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
      return {a[DW-1], a} + {b[DW-1], b};
   endfunction

   state_t                state_q, state_d;
   logic [IW-1:0]         ch_q, ch_d;
   logic signed [DW-1:0]  error_q, error_d, p_q, p_d;
   logic signed [DW-1:0]  gp_q, gp_d, gi_q, gi_d;
   logic signed [DW-1:0]  acc_q [N_CH];
   logic signed [DW-1:0]  acc_d [N_CH];
   logic [N_CH*DW-1:0]    out_q, out_d;
   logic [N_CH-1:0]       out_valid_q, out_valid_d;

   logic                  arb_en, arb_found;
   logic [N_CH-1:0]       arb_grant;
   logic [IW-1:0]         arb_idx;
   logic signed [DW-1:0]  mul_a, scaled;
   logic signed [2*DW-1:0] prod;

   assign arb_en = (state_q == IDLE) && ce && resetn;

   rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_arb (
      .aclk      (aclk),
      .resetn    (resetn),
      .en        (arb_en),
      .req       (req_valid),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .found     (arb_found)
   );

   // The only multiplier: kp in MUL_P, ki otherwise.
   assign mul_a  = (state_q == MUL_P) ? gp_q : gi_q;
   assign prod   = (2*DW)'(mul_a) * (2*DW)'(error_q);
   assign scaled = prod[DATA_WIDTH_DECIMAL +: DW];

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      error_d     = error_q;
      p_d         = p_q;
      gp_d        = gp_q;
      gi_d        = gi_q;
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = '0;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d = MUL_P;
               ch_d    = arb_idx;
               error_d = $signed(reference[arb_idx*DW +: DW]) - $signed(in[arb_idx*DW +: DW]);
               gp_d    = kp[arb_idx*DW +: DW];
               gi_d    = ki[arb_idx*DW +: DW];
            end
         end
         MUL_P: begin
            p_d     = scaled;
            state_d = MUL_I;
         end
         MUL_I: begin
            acc_d[ch_q] = clamp(add_wide(acc_q[ch_q], scaled), max, min);
            state_d     = SAT;
         end
         SAT: begin
            out_d[ch_q*DW +: DW] = clamp(add_wide(p_q, acc_q[ch_q]), max, min);
            out_valid_d[ch_q]    = 1'b1;
            state_d              = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A clear overrides an accumulation landing on the same edge.
      for (int i = 0; i < N_CH; i++) begin
         if (int_clr[i]) acc_d[i] = '0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         error_q     <= '0;
         p_q         <= '0;
         gp_q        <= '0;
         gi_q        <= '0;
         out_q       <= '0;
         out_valid_q <= '0;
         for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
      end else if (ce) begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         error_q     <= error_d;
         p_q         <= p_d;
         gp_q        <= gp_d;
         gi_q        <= gi_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
      end
   end

   assign req_ready = arb_grant;
   assign out       = out_q;
   assign out_valid = (ce && resetn) ? out_valid_q : '0;
endmodule

// File: tb/tb_pi_mux_l1.sv
// Randomized scoreboard bench for pi_mux_l1 with a transaction-level regulator model.
module tb_pi_mux_l1;
   localparam int N_CH = 4;
   localparam int DW   = 32;
   localparam logic [31:0] Q1  = 32'h0100_0000;
   localparam logic [31:0] QH  = 32'h0080_0000;
   localparam logic [31:0] QQ  = 32'h0040_0000;

   logic                  aclk, resetn, ce;
   logic [N_CH-1:0]       req_valid, req_ready, int_clr, out_valid;
   logic [N_CH*DW-1:0]    tb_in, tb_ref, tb_kp, tb_ki, tb_out;
   logic [DW-1:0]         tb_max, tb_min;

   pi_mux_l1 dut (
      .aclk(aclk), .resetn(resetn), .ce(ce), .req_valid(req_valid), .req_ready(req_ready),
      .in(tb_in), .reference(tb_ref), .kp(tb_kp), .ki(tb_ki), .max(tb_max), .min(tb_min),
      .int_clr(int_clr), .out(tb_out), .out_valid(out_valid)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct { int ch; logic [127:0] out; int due; } item_t;
   item_t sb[$];
   item_t pitem;
   bit    pend;

   int n_checks = 0, n_fail = 0, cyc = 0;
   int gnt_ch[$], gnt_cyc[$];
   int last_gnt_cyc = -1, last_ov_cyc = -1;

   longint m_acc [N_CH];
   longint m_out [N_CH];
   bit     m_busy;
   int     m_stage, m_ch, m_last;
   longint m_err, m_kp, m_ki, m_p;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic longint s32(input logic [31:0] v);
      logic signed [31:0] t;
      t = v;
      return longint'(t);
   endfunction

   function automatic longint mulq(input longint a, input longint b);
      longint pr;
      pr = a * b;
      return s32(pr[55:24]);
   endfunction

   function automatic longint clampm(input longint v);
      if (v > s32(tb_max)) return s32(tb_max);
      if (v < s32(tb_min)) return s32(tb_min);
      return v;
   endfunction

   function automatic logic [127:0] pack_out();
      logic [127:0] r;
      for (int i = 0; i < N_CH; i++) r[i*32 +: 32] = m_out[i][31:0];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin m_acc[i] = 0; m_out[i] = 0; end
      m_busy = 0; m_stage = 0; m_last = N_CH - 1; pend = 0;
   endtask

   // One clock cycle: check grant, advance the model across the coming edge.
   task automatic tick();
      logic [N_CH-1:0] exp_rdy;
      int g, gch;
      #1;
      if (req_ready != '0) begin
         gch = -1;
         for (int c = 0; c < N_CH; c++) if (req_ready[c]) gch = c;
         gnt_ch.push_back(gch); gnt_cyc.push_back(cyc); last_gnt_cyc = cyc;
      end
      exp_rdy = '0;
      g = -1;
      if (!resetn) begin
         chk("req_ready_in_reset", req_ready, exp_rdy);
         model_reset();
      end else if (!ce) begin
         chk("req_ready_ce_low", req_ready, exp_rdy);
      end else begin
         if (pend) begin pitem.due = cyc; sb.push_back(pitem); pend = 0; end
         if (!m_busy)
            for (int k = 1; k <= N_CH; k++) begin
               int c;
               c = (m_last + k) % N_CH;
               if (g < 0 && req_valid[c]) g = c;
            end
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         if (m_busy) begin
            if (m_stage == 1) m_p = mulq(m_kp, m_err);
            else if (m_stage == 2) m_acc[m_ch] = clampm(m_acc[m_ch] + mulq(m_ki, m_err));
            else begin
               m_out[m_ch] = clampm(m_p + m_acc[m_ch]);
               pitem.ch = m_ch; pitem.out = pack_out(); pend = 1; m_busy = 0;
            end
            m_stage++;
         end
         for (int i = 0; i < N_CH; i++) if (int_clr[i]) m_acc[i] = 0;
         if (g >= 0) begin
            m_busy = 1; m_stage = 1; m_ch = g; m_last = g;
            m_err = s32(tb_ref[g*32 +: 32] - tb_in[g*32 +: 32]);
            m_kp = s32(tb_kp[g*32 +: 32]); m_ki = s32(tb_ki[g*32 +: 32]);
         end
      end
      @(negedge aclk);
      cyc++;
   endtask

   // Monitor: samples just before each rising edge.
   initial begin
      item_t it;
      forever begin
         @(negedge aclk);
         #4;
         if (out_valid != '0) begin
            last_ov_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_out_valid", out_valid, '0);
            else begin
               it = sb.pop_front();
               chk("out_valid_ch", out_valid, 128'(1) << it.ch);
               chk("out_valid_cycle", cyc, it.due);
               chk("out_value", tb_out, it.out);
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            chk("missing_out_valid", 0, 1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic set_ch(input int ch, input logic [31:0] i_v, input logic [31:0] r_v,
                         input logic [31:0] p_v, input logic [31:0] i_g);
      tb_in[ch*32 +: 32] = i_v; tb_ref[ch*32 +: 32] = r_v;
      tb_kp[ch*32 +: 32] = p_v; tb_ki[ch*32 +: 32] = i_g;
   endtask

   task automatic request(input int ch);
      req_valid = N_CH'(1) << ch; tick();
      req_valid = '0; tick(); tick(); tick();
   endtask

   task automatic do_reset();
      resetn = 1'b0; tick(); tick(); resetn = 1'b1;
   endtask

   function automatic logic [31:0] rq();
      if ($urandom_range(0, 7) == 0) return $urandom;
      return 32'(int'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000);
   endfunction

   initial begin
      resetn = 1'b0; ce = 1'b1; req_valid = '1; int_clr = '0;
      tb_in = '0; tb_ref = '0; tb_kp = '0; tb_ki = '0;
      tb_max = 32'h0400_0000; tb_min = 32'hFC00_0000;
      model_reset();
      @(negedge aclk);
      tick(); tick();
      chk("reset_out", tb_out, '0);
      chk("reset_out_valid", out_valid, '0);
      resetn = 1'b1; req_valid = '0;

      // Two updates on channel 0: 0.75 then 1.0
      set_ch(0, 32'h0, Q1, QH, QQ);
      request(0);
      chk("ch0_first", tb_out[31:0], 32'h00C0_0000);
      request(0);
      chk("ch0_second", tb_out[31:0], 32'h0100_0000);

      // Anti-windup on channel 1 with max 2.0
      tb_max = 32'h0200_0000;
      set_ch(1, 32'h0, Q1, 32'h0, Q1);
      request(1); chk("ch1_r1", tb_out[63:32], Q1);
      request(1); chk("ch1_r2", tb_out[63:32], 32'h0200_0000);
      request(1); chk("ch1_r3", tb_out[63:32], 32'h0200_0000);
      request(1); chk("ch1_r4", tb_out[63:32], 32'h0200_0000);
      set_ch(1, 32'h0, 32'hFF00_0000, 32'h0, Q1);
      request(1); chk("ch1_unwind", tb_out[63:32], Q1);
      tb_max = 32'h0400_0000;

      // Integrator clear coincident with MUL_I on channel 2
      set_ch(2, 32'h0, Q1, QH, Q1);
      req_valid = 4'b0100; tick();
      req_valid = '0; tick();
      int_clr = 4'b0100; tick();
      int_clr = '0; tick();
      chk("ch2_clr_out", tb_out[95:64], QH);
      set_ch(2, 32'h0, Q1, 32'h0, 32'h0);
      request(2); chk("ch2_acc_zero", tb_out[95:64], 32'h0);

      // Round-robin fairness after reset
      do_reset();
      gnt_ch.delete(); gnt_cyc.delete();
      req_valid = 4'b1111;
      repeat (29) tick();
      req_valid = 4'b0101;
      repeat (4) tick();
      req_valid = '0;
      repeat (4) tick();
      chk("rr_count", gnt_ch.size(), 9);
      if (gnt_ch.size() == 9) begin
         for (int k = 0; k < 9; k++) chk("rr_order", gnt_ch[k], (k == 8) ? 0 : k % 4);
         for (int k = 0; k < 8; k++) chk("rr_spacing", gnt_cyc[k+1] - gnt_cyc[k], 4);
      end

      // Clock-enable stall during MUL_P
      do_reset();
      set_ch(3, 32'h0, Q1, QH, 32'h0);
      begin
         int gc;
         gc = cyc;
         req_valid = 4'b1000; tick();
         req_valid = '0; ce = 1'b0;
         tick(); tick(); tick();
         ce = 1'b1;
         repeat (4) tick();
         chk("stall_grant_cycle", last_gnt_cyc, gc);
         chk("stall_latency", last_ov_cyc - gc, 7);
         chk("stall_value", tb_out[127:96], QH);
      end

      // Reset in the middle of MUL_I
      set_ch(0, 32'h0, Q1, QH, QQ);
      req_valid = 4'b0001; tick();
      req_valid = '0; tick();
      resetn = 1'b0; tick();
      resetn = 1'b1;
      chk("midreset_out", tb_out, '0);
      chk("midreset_out_valid", out_valid, '0);
      req_valid = 4'b1111; tick();
      chk("midreset_next_grant", gnt_ch[$], 0);
      req_valid = '0; tick(); tick(); tick();
      chk("midreset_ch0", tb_out[31:0], 32'h00C0_0000);
      tick();

      // Randomized traffic
      for (int blk = 0; blk < 8; blk++) begin
         tb_max = 32'($urandom_range(0, 32'h0800_0000));
         tb_min = 32'(-int'($urandom_range(0, 32'h0800_0000)));
         repeat (250) begin
            ce = ($urandom_range(0, 9) != 0);
            resetn = ($urandom_range(0, 399) != 0);
            req_valid = N_CH'($urandom_range(0, 15));
            for (int i = 0; i < N_CH; i++) begin
               int_clr[i] = ($urandom_range(0, 15) == 0);
               set_ch(i, rq(), rq(), rq(), rq());
            end
            tick();
         end
      end

      ce = 1'b1; resetn = 1'b1; req_valid = '0; int_clr = '0;
      repeat (8) tick();
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
